// File: rtl/mem_m_writer_if.sv
// Operand stream into the modulus memory writer: WIDTH-bit words with a valid/ready handshake.
interface mem_m_writer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mem_m_writer.sv
// Modulus RAM loader: writes NUM_WORDS stream words from address 0, then hands the
// address bus back to the MonPro reader and reports word count and XOR checksum.
module mem_m_writer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_WORDS  = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  mem_m_writer_if.slave         str,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_data,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done,
  output logic                  loaded,
  output logic [ADDR_WIDTH:0]   word_cnt,
  output logic [WIDTH-1:0]      checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);

  function automatic logic [WIDTH-1:0] xor_accum(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] word);
    return acc ^ word;
  endfunction

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [ADDR_WIDTH:0]   word_cnt_r;
  logic [WIDTH-1:0]      checksum_r;
  logic                  loaded_r;
  logic                  in_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  accept_s;
  logic                  restart_s;

  assign accept_s  = str.in_valid & in_ready_r;
  assign restart_s = start & ((state_r == IDLE) | (state_r == DONE));

  // Next-state decode; abort takes priority over start and over the final accept
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = LOAD;
        else       state_s = IDLE;
      end
      LOAD: begin
        if (abort)                                  state_s = IDLE;
        else if (accept_s && word_cnt_r == LAST_CNT) state_s = FLUSH;
        else                                        state_s = LOAD;
      end
      FLUSH: begin
        if (abort) state_s = IDLE;
        else       state_s = DONE;
      end
      DONE: begin
        if (start) state_s = LOAD;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, handshake/status flags (registered from next state) and load bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      loaded_r   <= 1'b0;
      wr_addr_r  <= '0;
      word_cnt_r <= '0;
      checksum_r <= '0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == LOAD);
      busy_r     <= (state_s == LOAD) || (state_s == FLUSH);
      done_r     <= (state_s == DONE);
      if (restart_s) begin
        wr_addr_r  <= '0;
        word_cnt_r <= '0;
        checksum_r <= '0;
        loaded_r   <= 1'b0;
      end else begin
        // A word accepted alongside abort is still counted; the RAM already saw it
        if (accept_s) begin
          wr_addr_r  <= wr_addr_r + ADDR_WIDTH'(1);
          word_cnt_r <= word_cnt_r + (ADDR_WIDTH + 1)'(1);
          checksum_r <= xor_accum(checksum_r, str.in_data);
        end else begin
          wr_addr_r  <= wr_addr_r;
          word_cnt_r <= word_cnt_r;
          checksum_r <= checksum_r;
        end
        if (state_s == DONE) loaded_r <= 1'b1;
        else                 loaded_r <= loaded_r;
      end
    end
  end

  assign str.in_ready = in_ready_r;
  assign ram_addr     = busy_r ? wr_addr_r : rd_addr;
  assign ram_data     = str.in_data;
  assign ram_we       = accept_s;
  assign busy         = busy_r;
  assign done         = done_r;
  assign loaded       = loaded_r;
  assign word_cnt     = word_cnt_r;
  assign checksum     = checksum_r;

endmodule

// File: tb/tb_mem_m_writer.sv
// Directed bench for mem_m_writer with a registered-in/registered-out RAM model behind it.
module tb_mem_m_writer;
  localparam int W  = 32;
  localparam int AW = 7;
  localparam int NW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_data;
  logic          ram_we;
  logic          busy;
  logic          done;
  logic          loaded;
  logic [AW:0]   word_cnt;
  logic [W-1:0]  checksum;

  mem_m_writer_if #(.WIDTH(W)) str ();

  mem_m_writer #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .str(str),
    .rd_addr(rd_addr), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .busy(busy), .done(done), .loaded(loaded), .word_cnt(word_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int we_cnt = 0;

  // lpm_ram_dq model: registered address/data/we, registered q
  logic [W-1:0]  mem [NW];
  logic [AW-1:0] addr_q;
  logic [W-1:0]  q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    addr_q <= ram_addr;
    q      <= mem[addr_q];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-address monitor: the k-th write of a load must land at address k
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      chk("wr_addr_seq", 64'(ram_addr), 64'(we_cnt[AW-1:0]));
      we_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    rd_addr = a;
    step();
    step();
    chk(tag, 64'(q), 64'(exp));
  endtask

  // Start a full load of words 0..NW-1; returns cycle of done pulse (-1 on timeout)
  task automatic run_load(input bit toggle, output int done_cyc, output logic ld_at_done);
    int c;
    int i;
    we_cnt     = 0;
    start      = 1'b1;
    step();
    start      = 1'b0;
    c          = 1;
    i          = 0;
    done_cyc   = -1;
    ld_at_done = 1'b0;
    while (c < 600 && done_cyc < 0) begin
      str.in_valid = ((!toggle) || c[0]) && (i < NW);
      str.in_data  = W'(i);
      #1;
      if (done) begin
        done_cyc   = c;
        ld_at_done = loaded;
      end
      if (str.in_valid && str.in_ready) i++;
      step();
      c++;
    end
    str.in_valid = 1'b0;
  endtask

  int           dcyc;
  logic         ld;
  logic [W-1:0] xs;
  bit           saw_done;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; rd_addr = '0;
    str.in_valid = 1'b0; str.in_data = '0;
    step();
    step();
    reset = 1'b0;
    str.in_valid = 1'b1;
    rd_addr = 7'd5;
    #1;
    chk("rst_in_ready", 64'(str.in_ready), 64'd0);
    chk("rst_busy",     64'(busy),         64'd0);
    chk("rst_done",     64'(done),         64'd0);
    chk("rst_loaded",   64'(loaded),       64'd0);
    chk("rst_word_cnt", 64'(word_cnt),     64'd0);
    chk("rst_checksum", 64'(checksum),     64'd0);
    chk("rst_ram_we",   64'(ram_we),       64'd0);
    chk("idle_ram_addr", 64'(ram_addr),    64'd5);
    str.in_valid = 1'b0;
    step();

    // Full load, valid held high
    run_load(1'b0, dcyc, ld);
    chk("done_cycle",      64'(dcyc),     64'd130);
    chk("loaded_with_done", 64'(ld),      64'd1);
    chk("we_pulses",       64'(we_cnt),   64'd128);
    chk("word_cnt_full",   64'(word_cnt), 64'd128);
    chk("checksum_full",   64'(checksum), 64'd0);
    chk("loaded_after",    64'(loaded),   64'd1);
    chk("busy_after",      64'(busy),     64'd0);
    read_chk("read_a0",   7'd0,   32'd0);
    read_chk("read_a127", 7'd127, 32'd127);

    // Full load with in_valid on every other cycle
    for (int k = 0; k < NW; k++) mem[k] = 32'hdead_beef;
    run_load(1'b1, dcyc, ld);
    chk("done_cycle_toggle",  64'(dcyc),     64'd257);
    chk("word_cnt_toggle",    64'(word_cnt), 64'd128);
    chk("we_pulses_toggle",   64'(we_cnt),   64'd128);
    read_chk("read_t64", 7'd64, 32'd64);
    read_chk("read_t1",  7'd1,  32'd1);

    // Abort after 40 accepts
    we_cnt = 0;
    xs = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      str.in_valid = 1'b1;
      str.in_data  = W'(k * 3 + 1) ^ 32'h5a00_0000;
      xs = xs ^ str.in_data;
      step();
    end
    str.in_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy",     64'(busy),         64'd0);
    chk("abort_in_ready", 64'(str.in_ready), 64'd0);
    chk("abort_loaded",   64'(loaded),       64'd0);
    chk("abort_word_cnt", 64'(word_cnt),     64'd40);
    chk("abort_checksum", 64'(checksum),     64'(xs));
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_we",      64'(we_cnt),   64'd40);

    // start during DONE goes straight back to LOAD
    we_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    str.in_valid = 1'b1;
    for (int k = 0; k < NW; k++) begin
      str.in_data = W'(k);
      step();
    end
    str.in_valid = 1'b0;
    step();
    chk("done_pulse", 64'(done), 64'd1);
    start = 1'b1;
    we_cnt = 0;
    step();
    start = 1'b0;
    chk("restart_busy",     64'(busy),         64'd1);
    chk("restart_in_ready", 64'(str.in_ready), 64'd1);
    chk("restart_loaded",   64'(loaded),       64'd0);
    chk("restart_word_cnt", 64'(word_cnt),     64'd0);
    chk("restart_done",     64'(done),         64'd0);

    // Reset mid-load at word 60
    str.in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      str.in_data = W'(k);
      step();
    end
    chk("pre_reset_cnt", 64'(word_cnt), 64'd60);
    reset = 1'b1;
    #1;
    chk("mrst_busy",     64'(busy),         64'd0);
    chk("mrst_in_ready", 64'(str.in_ready), 64'd0);
    chk("mrst_ram_we",   64'(ram_we),       64'd0);
    chk("mrst_word_cnt", 64'(word_cnt),     64'd0);
    chk("mrst_checksum", 64'(checksum),     64'd0);
    chk("mrst_loaded",   64'(loaded),       64'd0);
    str.in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    run_load(1'b0, dcyc, ld);
    chk("reload_done_cycle", 64'(dcyc),     64'd130);
    chk("reload_loaded",     64'(loaded),   64'd1);
    chk("reload_word_cnt",   64'(word_cnt), 64'd128);
    read_chk("reload_a99", 7'd99, 32'd99);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_m_writer.md
# mem_m_writer

Loader for the modulus memory of the Montgomery multiplier datapath. It accepts WIDTH-bit operand words over a valid/ready stream and writes them into the single-port registered RAM (lpm_ram_dq, registered input and output) at consecutive addresses starting at 0. When it is idle, it passes the MonPro core's read address through to the same RAM. It signals load completion and reports a word count and an XOR checksum so the host can confirm the modulus before a MonPro run starts.

## Interface
- WIDTH, 32, RAM data width (bits per modulus word)
- ADDR_WIDTH, 7, RAM address width
- NUM_WORDS, 128, words per load; legal range 1..2**ADDR_WIDTH
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a load at address 0; honoured in IDLE and DONE only
- abort  input  1  cancel an in-progress load; honoured in LOAD and FLUSH
- in_data  input  WIDTH  stream word
- in_valid  input  1  in_data is valid
- in_ready  output  1  writer accepts a word this cycle
- rd_addr  input  ADDR_WIDTH  consumer read address, used only when busy=0
- ram_addr  output  ADDR_WIDTH  RAM address: busy ? wr_addr : rd_addr (combinational)
- ram_data  output  WIDTH  RAM write data = in_data (combinational)
- ram_we  output  1  RAM write enable = in_valid & in_ready (combinational)
- busy  output  1  high in LOAD and FLUSH
- done  output  1  one-cycle pulse, load complete
- loaded  output  1  RAM holds a complete, unaborted load
- word_cnt  output  ADDR_WIDTH+1  words accepted in current or last load
- checksum  output  WIDTH  XOR of all words accepted in current or last load

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: in_ready=0, busy=0. On start, go to LOAD. On the same edge: wr_addr←0, word_cnt←0, checksum←0, loaded←0.
- LOAD: in_ready=1. Each accepted word (in_valid & in_ready) is written:
  - ram_we=1, ram_addr=wr_addr, ram_data=in_data in that cycle.
  - On the edge: wr_addr+1, word_cnt+1, checksum^=in_data.
  - If in_valid is low, nothing happens and the writer waits indefinitely.
- LOAD exit: the edge that accepts word NUM_WORDS-1 (word_cnt reaches NUM_WORDS) moves to FLUSH.
- wr_addr wrap: wr_addr is ADDR_WIDTH bits and wraps to 0 after 2**ADDR_WIDTH-1. This only occurs when NUM_WORDS=2**ADDR_WIDTH, at the final accept, and is harmless.
- FLUSH: one cycle, in_ready=0, busy=1. It lets the RAM input register commit the final write before the consumer regains the address bus. Next state is DONE.
- DONE: one cycle, done=1, loaded←1 on entry, busy=0. Next state is IDLE, or LOAD if start=1 in this cycle.
- abort in LOAD or FLUSH: go to IDLE next edge. loaded stays 0, no done pulse. word_cnt and checksum hold the partial values. A word accepted in the abort cycle is still written and counted.
- abort and start together in LOAD/FLUSH: abort wins. start is ignored in LOAD/FLUSH.
- abort outside LOAD/FLUSH: ignored.
- Reset (any time, including mid-load): state IDLE, in_ready=0, busy=0, done=0, loaded=0, wr_addr=0, word_cnt=0, checksum=0. RAM contents are undefined after a mid-load reset; loaded=0 reflects this.

## Timing
- Write latency: the word accepted in cycle N is registered by the RAM at edge N and readable at that address from cycle N+1.
- Consumer read latency: rd_addr in cycle N gives RAM q valid at cycle N+2 (registered address plus registered output). The writer adds no latency.
- While busy=1, rd_addr is ignored and RAM q reflects write addresses; the consumer must not use q.
- Minimum load duration: NUM_WORDS+2 cycles from the first LOAD cycle to the done pulse, with in_valid held high (NUM_WORDS accepts, FLUSH, DONE).
- done and loaded rise in the same cycle. loaded falls on the edge that leaves IDLE/DONE on start.
- in_ready, busy, done and loaded are decoded from registered state and are glitch-free.

## Test plan
- Reset, then idle: all outputs 0 and ram_we=0. rd_addr=5 gives ram_addr=5.
- start, then 128 words 0..127 with in_valid held high:
  - 128 ram_we pulses at addr 0..127.
  - FLUSH, then done pulse at cycle 130 after start.
  - loaded=1, word_cnt=128, checksum=0.
  - Reads of addr 0 and 127 return 0 and 127 two cycles after rd_addr.
- Same load with in_valid toggling every other cycle: identical RAM contents, word_cnt=128, done after 257 cycles.
- abort after 40 accepts:
  - Returns to IDLE, no done, loaded=0, word_cnt=40.
  - checksum equals the XOR of the first 40 words.
- start asserted in the DONE cycle: goes directly to LOAD, loaded drops, word_cnt=0.
- reset asserted mid-load at word 60: outputs return immediately to reset values. A subsequent full load completes normally.
